// File: rtl/digclock_pkg.sv
// digclock_pkg: key debounce FSM state encoding, default timing constants and counter width helper.
package digclock_pkg;

    typedef enum logic [2:0] {IDLE, DB_DN, PRESSED, HELD, DB_UP} key_state_t;

    localparam int N_KEYS_DEF      = 4;
    localparam int CLK_PER_MS_DEF  = 50000;
    localparam int DEBOUNCE_MS_DEF = 20;
    localparam int LONG_MS_DEF     = 1000;
    localparam int REPEAT_MS_DEF   = 200;

    function automatic int cnt_w(input int max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/key_fsm_cell.sv
// key_fsm_cell: one key's 2-FF synchroniser, debounce/hold FSM and event pulses.
// Auto-repeat in HELD is built only when KEY_REPEAT_EN is defined.
module key_fsm_cell
    import digclock_pkg::*;
#(
    parameter int DEBOUNCE_MS = DEBOUNCE_MS_DEF,
    parameter int LONG_MS     = LONG_MS_DEF,
    parameter int REPEAT_MS   = REPEAT_MS_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic i_tick,
    input  logic i_key_n,
    output logic o_level,
    output logic o_press,
    output logic o_release,
    output logic o_long,
    output logic o_repeat
);

    localparam int DW = cnt_w(DEBOUNCE_MS);
    localparam int HW = cnt_w(LONG_MS);
    localparam logic [DW-1:0] DB_LAST   = DW'(DEBOUNCE_MS - 1);
    localparam logic [HW-1:0] HOLD_LAST = HW'(LONG_MS - 1);
    localparam logic [HW-1:0] HOLD_SAT  = HW'(LONG_MS);

    key_state_t    r_state, w_state_nx;
    logic          r_sync1, r_sync_n;
    logic [DW-1:0] r_db, w_db_nx;
    logic [HW-1:0] r_hold, w_hold_nx;
    logic          r_long_flag, w_long_flag_nx;
    logic          r_level, w_level_nx;
    logic          r_press, w_press_nx;
    logic          r_release, w_release_nx;
    logic          r_long, w_long_nx;

`ifdef KEY_REPEAT_EN
    localparam int RW = cnt_w(REPEAT_MS);
    localparam logic [RW-1:0] RPT_LAST = RW'(REPEAT_MS - 1);
    logic [RW-1:0] r_rpt, w_rpt_nx;
    logic          r_repeat, w_repeat_nx;
`endif

    always_comb begin
        w_state_nx     = r_state;
        w_db_nx        = r_db;
        w_hold_nx      = r_hold;
        w_long_flag_nx = r_long_flag;
        w_level_nx     = r_level;
        w_press_nx     = 1'b0;
        w_release_nx   = 1'b0;
        w_long_nx      = 1'b0;
`ifdef KEY_REPEAT_EN
        w_rpt_nx       = r_rpt;
        w_repeat_nx    = 1'b0;
`endif
        // a level change always wins over a coincident tick
        case (r_state)
            IDLE: if (!r_sync_n) begin
                w_state_nx = DB_DN;
                w_db_nx    = '0;
            end
            DB_DN: if (r_sync_n) w_state_nx = IDLE;
            else if (i_tick) begin
                if (r_db == DB_LAST) begin
                    w_state_nx = PRESSED;
                    w_press_nx = 1'b1;
                    w_level_nx = 1'b1;
                    w_hold_nx  = '0;
                end else w_db_nx = r_db + DW'(1);
            end
            PRESSED: if (r_sync_n) begin
                w_state_nx = DB_UP;
                w_db_nx    = '0;
            end else if (i_tick) begin
                if (r_hold == HOLD_LAST) begin
                    w_state_nx     = HELD;
                    w_long_nx      = 1'b1;
                    w_hold_nx      = HOLD_SAT;
                    w_long_flag_nx = 1'b1;
`ifdef KEY_REPEAT_EN
                    w_rpt_nx       = '0;
`endif
                end else w_hold_nx = r_hold + HW'(1);
            end
            HELD: if (r_sync_n) begin
                w_state_nx = DB_UP;
                w_db_nx    = '0;
            end
`ifdef KEY_REPEAT_EN
            else if (i_tick) begin
                w_repeat_nx = (r_rpt == RPT_LAST);
                w_rpt_nx    = (r_rpt == RPT_LAST) ? '0 : r_rpt + RW'(1);
            end
`endif
            DB_UP: if (!r_sync_n) w_state_nx = r_long_flag ? HELD : PRESSED;
            else if (i_tick) begin
                if (r_db == DB_LAST) begin
                    w_state_nx     = IDLE;
                    w_release_nx   = 1'b1;
                    w_level_nx     = 1'b0;
                    w_long_flag_nx = 1'b0;
                end else w_db_nx = r_db + DW'(1);
            end
            default: w_state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync1     <= 1'b1;
            r_sync_n    <= 1'b1;
            r_state     <= IDLE;
            r_db        <= '0;
            r_hold      <= '0;
            r_long_flag <= 1'b0;
            r_level     <= 1'b0;
            r_press     <= 1'b0;
            r_release   <= 1'b0;
            r_long      <= 1'b0;
        end else begin
            r_sync1     <= i_key_n;
            r_sync_n    <= r_sync1;
            r_state     <= w_state_nx;
            r_db        <= w_db_nx;
            r_hold      <= w_hold_nx;
            r_long_flag <= w_long_flag_nx;
            r_level     <= w_level_nx;
            r_press     <= w_press_nx;
            r_release   <= w_release_nx;
            r_long      <= w_long_nx;
        end
    end

`ifdef KEY_REPEAT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rpt    <= '0;
            r_repeat <= 1'b0;
        end else begin
            r_rpt    <= w_rpt_nx;
            r_repeat <= w_repeat_nx;
        end
    end

    assign o_repeat = r_repeat;
`else
    logic w_unused_rpt;
    assign w_unused_rpt = (REPEAT_MS != 0);
    assign o_repeat     = 1'b0;
`endif

    assign o_level   = r_level;
    assign o_press   = r_press;
    assign o_release = r_release;
    assign o_long    = r_long;

endmodule

// File: rtl/key_debounce.sv
// key_debounce: DE2 push-button front end; shared 1 ms prescaler feeding one key_fsm_cell per key.
// Define KEY_REPEAT_EN to enable key_repeat pulses while a key is held past LONG_MS.
module key_debounce
    import digclock_pkg::*;
#(
    parameter int N_KEYS      = N_KEYS_DEF,
    parameter int CLK_PER_MS  = CLK_PER_MS_DEF,
    parameter int DEBOUNCE_MS = DEBOUNCE_MS_DEF,
    parameter int LONG_MS     = LONG_MS_DEF,
    parameter int REPEAT_MS   = REPEAT_MS_DEF
) (
    input  logic              CLOCK_50,
    input  logic              rst,
    input  logic [N_KEYS-1:0] KEY,
    output logic [N_KEYS-1:0] key_level,
    output logic [N_KEYS-1:0] key_press,
    output logic [N_KEYS-1:0] key_release,
    output logic [N_KEYS-1:0] key_long,
    output logic [N_KEYS-1:0] key_repeat
);

    localparam int PW = cnt_w(CLK_PER_MS - 1);

    logic [PW-1:0] r_pre;
    logic          w_tick;

    assign w_tick = (r_pre == PW'(CLK_PER_MS - 1));

    always_ff @(posedge CLOCK_50) begin
        if (rst || w_tick) r_pre <= '0;
        else r_pre <= r_pre + PW'(1);
    end

    for (genvar k = 0; k < N_KEYS; k++) begin : g_key
        key_fsm_cell #(
            .DEBOUNCE_MS(DEBOUNCE_MS),
            .LONG_MS    (LONG_MS),
            .REPEAT_MS  (REPEAT_MS)
        ) u_cell (
            .clk      (CLOCK_50),
            .rst      (rst),
            .i_tick   (w_tick),
            .i_key_n  (KEY[k]),
            .o_level  (key_level[k]),
            .o_press  (key_press[k]),
            .o_release(key_release[k]),
            .o_long   (key_long[k]),
            .o_repeat (key_repeat[k])
        );
    end

endmodule

// File: tb/tb_key_debounce.sv
// tb_key_debounce: directed scenarios plus random key activity, checked every cycle against a
// behavioural model built from accepted level, tick counts and a 2-cycle input delay.
module tb_key_debounce;

    localparam int N   = 4;
    localparam int CPM = 10;
    localparam int DBM = 3;
    localparam int LM  = 10;
    localparam int RM  = 4;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [N-1:0] key = '1;
    logic [N-1:0] key_level, key_press, key_release, key_long, key_repeat;

    always #5 clk = ~clk;

    key_debounce #(
        .N_KEYS(N), .CLK_PER_MS(CPM), .DEBOUNCE_MS(DBM), .LONG_MS(LM), .REPEAT_MS(RM)
    ) dut (
        .CLOCK_50   (clk),
        .rst        (rst),
        .KEY        (key),
        .key_level  (key_level),
        .key_press  (key_press),
        .key_release(key_release),
        .key_long   (key_long),
        .key_repeat (key_repeat)
    );

    int n_chk  = 0;
    int n_fail = 0;
    int cyc    = 0;

    task automatic chk_vec(input string nm, input logic [N-1:0] got, input logic [N-1:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s cyc=%0d got=%b expected=%b", nm, cyc, got, exp);
        end
    endtask

    task automatic chk_rng(input string nm, input int got, input int lo, input int hi);
        n_chk++;
        if (got < lo || got > hi) begin
            n_fail++;
            $display("FAIL %s cyc=%0d got=%0d expected=%0d..%0d", nm, cyc, got, lo, hi);
        end
    endtask

    // Model: pressed keys are accepted once DBM ticks land while the delayed input has disagreed
    // with the accepted level for at least two consecutive cycles; hold/repeat likewise count
    // only ticks seen while the delayed input agrees with a pressed level for two cycles.
    logic [N-1:0] m_s1 = '1, m_s2 = '1, m_prev = '1, m_acc = '0;
    logic [N-1:0] e_press = '0, e_rel = '0, e_long = '0, e_rpt = '0, e_level = '0;
    int m_pre = 0;
    int m_db[N], m_hold[N], m_rpt[N];
    bit m_ld[N];
    bit m_tick, m_at, m_now;

    always @(posedge clk) begin
        cyc++;
        e_press = '0;
        e_rel   = '0;
        e_long  = '0;
        e_rpt   = '0;
        if (rst) begin
            m_s1 = '1; m_s2 = '1; m_prev = '1; m_acc = '0; m_pre = 0;
            for (int k = 0; k < N; k++) begin
                m_db[k] = 0; m_hold[k] = 0; m_rpt[k] = 0; m_ld[k] = 0;
            end
        end else begin
            m_tick = (m_pre == CPM - 1);
            m_pre  = m_tick ? 0 : m_pre + 1;
            for (int k = 0; k < N; k++) begin
                m_now = !m_s2[k];
                m_at  = m_tick && (m_s2[k] == m_prev[k]);
                if (m_now == m_acc[k]) begin
                    m_db[k] = 0;
                    if (m_acc[k] && m_at) begin
                        if (!m_ld[k]) begin
                            m_hold[k]++;
                            if (m_hold[k] == LM) begin
                                e_long[k] = 1'b1; m_ld[k] = 1; m_rpt[k] = 0;
                            end
                        end
`ifdef KEY_REPEAT_EN
                        else begin
                            m_rpt[k]++;
                            if (m_rpt[k] == RM) begin
                                e_rpt[k] = 1'b1; m_rpt[k] = 0;
                            end
                        end
`endif
                    end
                end else if (m_at) begin
                    m_db[k]++;
                    if (m_db[k] == DBM) begin
                        m_db[k]  = 0;
                        m_acc[k] = m_now;
                        if (m_now) begin
                            e_press[k] = 1'b1; m_hold[k] = 0; m_ld[k] = 0;
                        end else e_rel[k] = 1'b1;
                    end
                end
            end
            m_prev = m_s2;
            m_s2   = m_s1;
            m_s1   = key;
        end
        e_level = m_acc;
    end

    always @(negedge clk) begin
        if (cyc > 0) begin
            chk_vec("level",   key_level,   e_level);
            chk_vec("press",   key_press,   e_press);
            chk_vec("release", key_release, e_rel);
            chk_vec("long",    key_long,    e_long);
            chk_vec("repeat",  key_repeat,  e_rpt);
        end
    end

    int c_press[N], c_rel[N], c_long[N], c_rpt[N];
    int t_press[N], t_long[N], t_rpt1[N];

    always @(negedge clk) begin
        for (int k = 0; k < N; k++) begin
            if (key_press[k] === 1'b1) begin c_press[k]++; t_press[k] = cyc; end
            if (key_release[k] === 1'b1) c_rel[k]++;
            if (key_long[k] === 1'b1) begin c_long[k]++; t_long[k] = cyc; end
            if (key_repeat[k] === 1'b1) begin
                if (c_rpt[k] == 0) t_rpt1[k] = cyc;
                c_rpt[k]++;
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    task automatic clr();
        for (int k = 0; k < N; k++) begin
            c_press[k] = 0; c_rel[k] = 0; c_long[k] = 0; c_rpt[k] = 0;
            t_press[k] = 0; t_long[k] = 0; t_rpt1[k] = 0;
        end
    endtask

    int t0, r0;

    initial begin
        clr();
        step(3);
        chk_vec("reset_level", key_level, '0);
        chk_vec("reset_press", key_press, '0);
        rst = 1'b0;

        // clean press and release of KEY[0]
        clr();
        t0 = cyc;
        key[0] = 1'b0;
        step(60);
        chk_rng("t1_press_cnt", c_press[0], 1, 1);
        chk_rng("t1_press_lat", t_press[0] - t0, 22, 35);
        chk_rng("t1_level", int'(key_level[0]), 1, 1);
        key[0] = 1'b1;
        step(50);
        chk_rng("t1_release_cnt", c_rel[0], 1, 1);
        chk_rng("t1_long_cnt", c_long[0], 0, 0);
        chk_rng("t1_level_off", int'(key_level[0]), 0, 0);

        // bouncing KEY[1]
        clr();
        for (int i = 0; i < 8; i++) begin
            key[1] = ~key[1];
            step(5);
        end
        chk_rng("t2_no_bounce_evt", c_press[1] + c_rel[1], 0, 0);
        t0 = cyc;
        key[1] = 1'b0;
        step(45);
        chk_rng("t2_press_cnt", c_press[1], 1, 1);
        chk_rng("t2_press_lat", t_press[1] - t0, 22, 35);
        key[1] = 1'b1;
        step(50);

        // long hold of KEY[2]
        clr();
        key[2] = 1'b0;
        step(200);
        chk_rng("t3_long_cnt", c_long[2], 1, 1);
        chk_rng("t3_long_delay", t_long[2] - t_press[2], LM * CPM, LM * CPM);
`ifdef KEY_REPEAT_EN
        chk_rng("t3_repeat_gap", t_rpt1[2] - t_long[2], RM * CPM, RM * CPM);
`else
        chk_rng("t3_repeat_cnt", c_rpt[2], 0, 0);
`endif

        // short release glitch while held
        r0 = c_rpt[2];
        key[2] = 1'b1;
        step(15);
        key[2] = 1'b0;
        step(100);
        chk_rng("t4_no_release", c_rel[2], 0, 0);
        chk_rng("t4_single_long", c_long[2], 1, 1);
        chk_rng("t4_level", int'(key_level[2]), 1, 1);
`ifdef KEY_REPEAT_EN
        chk_rng("t4_repeat_more", c_rpt[2] - r0, 1, 3);
`endif
        key[2] = 1'b1;
        step(50);
        chk_rng("t4_release_cnt", c_rel[2], 1, 1);

        // simultaneous presses
        clr();
        key = key & 4'b0110;
        step(50);
        chk_rng("t5_press0", c_press[0], 1, 1);
        chk_rng("t5_press3", c_press[3], 1, 1);
        chk_rng("t5_same_cycle", t_press[3] - t_press[0], 0, 0);
        key = '1;
        step(50);

        // reset while KEY[1] held
        key[1] = 1'b0;
        step(50);
        rst = 1'b1;
        step(1);
        chk_vec("t6_rst_level", key_level, '0);
        chk_vec("t6_rst_press", key_press | key_release | key_long | key_repeat, '0);
        rst = 1'b0;
        clr();
        t0 = cyc;
        step(45);
        chk_rng("t6_repress_cnt", c_press[1], 1, 1);
        chk_rng("t6_repress_lat", t_press[1] - t0, 22, 35);
        key[1] = 1'b1;
        step(50);

        // random activity, checked by the model every cycle
        for (int i = 0; i < 80; i++) begin
            for (int k = 0; k < N; k++)
                if ($urandom_range(2) == 0) key[k] = ~key[k];
            if ($urandom_range(29) == 0) begin
                rst = 1'b1;
                step($urandom_range(1, 2));
                rst = 1'b0;
            end
            step($urandom_range(1, 150));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
